// File: rtl/ysyx_22040038_ifu.sv
// ysyx_22040038_ifu: single-outstanding instruction fetch unit feeding ID through a held output register,
// with EX redirect that squashes in-flight and held work.
module ysyx_22040038_ifu #(
  parameter int              XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);
  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;
  logic [1:0]      r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic            r_id_valid, w_id_valid_nxt;
  logic [31:0]     r_id_instr;
  logic [XLEN-1:0] r_id_pc;
  logic            w_in_req, w_in_wait, w_in_hold, w_in_drop;
  logic            w_accept, w_take, w_pending;
  always_comb begin
    w_in_req       = r_state == S_REQ;
    w_in_wait      = r_state == S_WAIT;
    w_in_hold      = r_state == S_HOLD;
    w_in_drop      = r_state == S_DROP;
    w_accept       = w_in_req & imem_req_ready;
    w_take         = w_in_wait & imem_rsp_valid & ~redirect_valid;
    // a response is still owed after this edge: squashed work must go through DROP
    w_pending      = w_accept | ((w_in_wait | w_in_drop) & ~imem_rsp_valid);
    w_state_nxt    = redirect_valid                ? (w_pending ? S_DROP : S_REQ)
                   : w_accept                      ? S_WAIT
                   : w_in_wait & imem_rsp_valid    ? S_HOLD
                   : w_in_hold & id_ready          ? S_REQ
                   : w_in_drop & imem_rsp_valid    ? S_REQ
                   : r_state;
    w_pc_nxt       = redirect_valid ? {redirect_pc[XLEN-1:2], 2'b00}
                   : w_take         ? r_pc + XLEN'(4)
                   : r_pc;
    w_id_valid_nxt = redirect_valid         ? 1'b0
                   : w_take                 ? 1'b1
                   : w_in_hold & id_ready   ? 1'b0
                   : r_id_valid;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_REQ;
      r_pc       <= RESET_PC;
      r_id_valid <= 1'b0;
      r_id_instr <= 32'h0000_0013;
      r_id_pc    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_id_valid <= w_id_valid_nxt;
      if (w_take) begin
        r_id_instr <= imem_rsp_data;
        r_id_pc    <= r_pc;
      end
    end
  end
  assign imem_req_valid = w_in_req & rst_n;
  assign imem_req_addr  = r_pc;
  assign id_valid       = r_id_valid;
  assign id_instr       = r_id_instr;
  assign id_pc          = r_id_pc;
endmodule

// File: tb/tb_ysyx_22040038_ifu.sv
// tb_ysyx_22040038_ifu: scoreboard bench for the fetch unit; expected {pc, instr} pairs are queued
// when a fetch is served and popped when the word is presented to ID.
module tb_ysyx_22040038_ifu;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid, id_ready;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [95:0] q[$];
  logic [95:0] e;
  logic [63:0] exp_pc;
  int          n_tests = 0;
  int          n_fail  = 0;

  ysyx_22040038_ifu dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  // serve one fetch: accept the pending request, answer lat cycles later, queue the expected word
  task automatic issue(input logic [31:0] data, input int lat);
    int k;
    k = 0;
    while (imem_req_valid !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (imem_req_valid !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: req_valid=%b required 1", imem_req_valid);
    end
    q.push_back({exp_pc, data});
    exp_pc += 64'd4;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    repeat (lat - 1) @(negedge clk);
    imem_rsp_data  = data;
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; id_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0000_0013 || id_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: req_valid=%b id_valid=%b instr=%h pc=%h required 0 0 00000013 0",
               imem_req_valid, id_valid, id_instr, id_pc);
    end
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    @(negedge clk);
  endtask

  task automatic test_first_fetch;
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0000) begin
      n_fail++;
      $display("FAIL first_req: valid=%b addr=%h required 1 80000000", imem_req_valid, imem_req_addr);
    end
    issue(32'h0010_0093, 1);
    e = q.pop_front();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0] || id_pc !== 64'h8000_0000) begin
      n_fail++;
      $display("FAIL first_word: valid=%b pc=%h instr=%h required 1 %h %h", id_valid, id_pc, id_instr, e[95:32], e[31:0]);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] words [3];
    words[0] = 32'h0000_0513; words[1] = 32'h00a5_0533; words[2] = 32'hfff5_0513;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        for (int c = 0; c < 3; c++) begin
          n_tests++;
          if (imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
            n_fail++;
            $display("FAIL addr_stable: valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, exp_pc);
          end
          @(negedge clk);
        end
      end
      issue(words[i], 1 + i);
      e = q.pop_front();
      n_tests++;
      if (id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0] || id_pc !== 64'h8000_0004 + 64'(4 * i)) begin
        n_fail++;
        $display("FAIL b2b_%0d: valid=%b pc=%h instr=%h required 1 %h %h", i, id_valid, id_pc, id_instr, e[95:32], e[31:0]);
      end
      id_ready = 1'b1;
      @(negedge clk);
      id_ready = 1'b0;
    end
  endtask

  task automatic test_hold;
    issue(32'h1234_5678, 1);
    e = q.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (imem_req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0]) begin
        n_fail++;
        $display("FAIL hold_%0d: req_valid=%b id_valid=%b pc=%h instr=%h required 0 1 %h %h",
                 c, imem_req_valid, id_valid, id_pc, id_instr, e[95:32], e[31:0]);
      end
      @(negedge clk);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== exp_pc) begin
      n_fail++;
      $display("FAIL hold_release: id_valid=%b req_valid=%b addr=%h required 0 1 %h", id_valid, imem_req_valid, imem_req_addr, exp_pc);
    end
  endtask

  task automatic test_redirect_wait;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0103;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_drop: req_valid=%b id_valid=%b required 0 0", imem_req_valid, id_valid);
    end
    @(negedge clk);
    imem_rsp_data  = 32'hdead_beef;
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0100) begin
      n_fail++;
      $display("FAIL redirect_target: id_valid=%b req_valid=%b addr=%h required 0 1 0000000080000100",
               id_valid, imem_req_valid, imem_req_addr);
    end
    exp_pc = 64'h8000_0100;
    issue(32'h0040_006f, 2);
    e = q.pop_front();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0]) begin
      n_fail++;
      $display("FAIL redirect_word: valid=%b pc=%h instr=%h required 1 %h %h", id_valid, id_pc, id_instr, e[95:32], e[31:0]);
    end
    // squash the held word with a redirect while ID is stalled
    redirect_valid = 1'b1;
    redirect_pc    = 64'h8000_0200;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 64'h8000_0200) begin
      n_fail++;
      $display("FAIL redirect_hold: id_valid=%b req_valid=%b addr=%h required 0 1 0000000080000200",
               id_valid, imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_wrap;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req: valid=%b addr=%h required 1 fffffffffffffffc", imem_req_valid, imem_req_addr);
    end
    exp_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    issue(32'h0000_0073, 1);
    e = q.pop_front();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0]) begin
      n_fail++;
      $display("FAIL wrap_word: valid=%b pc=%h instr=%h required 1 %h %h", id_valid, id_pc, id_instr, e[95:32], e[31:0]);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    n_tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 64'd0) begin
      n_fail++;
      $display("FAIL wrap_next: valid=%b addr=%h required 1 0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_mid;
    imem_req_ready = 1'b1;
    @(negedge clk);
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (imem_req_valid !== 1'b0 || id_valid !== 1'b0 || id_instr !== 32'h0000_0013 || id_pc !== 64'd0) begin
      n_fail++;
      $display("FAIL midreset: req_valid=%b id_valid=%b instr=%h pc=%h required 0 0 00000013 0",
               imem_req_valid, id_valid, id_instr, id_pc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_data  = 32'hbad0_bad0;
    imem_rsp_valid = 1'b1;
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    n_tests++;
    if (id_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL stray_rsp: id_valid=%b req_valid=%b addr=%h required 0 1 %h", id_valid, imem_req_valid, imem_req_addr, RESET_PC);
    end
    exp_pc = RESET_PC;
    issue(32'h0020_0113, 1);
    e = q.pop_front();
    n_tests++;
    if (id_valid !== 1'b1 || id_pc !== e[95:32] || id_instr !== e[31:0]) begin
      n_fail++;
      $display("FAIL post_reset_word: valid=%b pc=%h instr=%h required 1 %h %h", id_valid, id_pc, id_instr, e[95:32], e[31:0]);
    end
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_hold();
    test_redirect_wait();
    test_wrap();
    test_reset_mid();
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
